// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs, states,
// datapath mux selects and the registered control-word payload.
package cpu_ctrl_pkg;

   localparam int unsigned STATE_W = 6;
   localparam int unsigned OP_W    = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [OP_W-1:0] FN_SLL = 6'h00;
   localparam logic [OP_W-1:0] FN_SRL = 6'h02;
   localparam logic [OP_W-1:0] FN_SRA = 6'h03;
   localparam logic [OP_W-1:0] FN_JR  = 6'h08;
   localparam logic [OP_W-1:0] FN_ADD = 6'h20;
   localparam logic [OP_W-1:0] FN_SUB = 6'h22;
   localparam logic [OP_W-1:0] FN_AND = 6'h24;
   localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_PASSA = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_CMP   = 3'b111;

   localparam logic       ALUA_PC = 1'b0;
   localparam logic       ALUA_A  = 1'b1;

   localparam logic [1:0] ALUB_B       = 2'd0;
   localparam logic [1:0] ALUB_4       = 2'd1;
   localparam logic [1:0] ALUB_SEXT    = 2'd2;
   localparam logic [1:0] ALUB_SEXT_SH = 2'd3;

   localparam logic [2:0] IORD_PC     = 3'd0;
   localparam logic [2:0] IORD_ALUOUT = 3'd1;
   localparam logic [2:0] IORD_OPC    = 3'd2;
   localparam logic [2:0] IORD_OVF    = 3'd3;

   localparam logic [2:0] PCS_ALU    = 3'd0;
   localparam logic [2:0] PCS_ALUOUT = 3'd1;
   localparam logic [2:0] PCS_JUMP   = 3'd2;
   localparam logic [2:0] PCS_MDR    = 3'd3;
   localparam logic [2:0] PCS_A      = 3'd4;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;
   localparam logic [1:0] RD_SP = 2'd3;

   localparam logic [2:0] M2R_ALUOUT = 3'd0;
   localparam logic [2:0] M2R_MDR    = 3'd1;
   localparam logic [2:0] M2R_SHIFT  = 3'd2;
   localparam logic [2:0] M2R_LT     = 3'd3;
   localparam logic [2:0] M2R_SP     = 3'd4;
   localparam logic [2:0] M2R_PC     = 3'd5;

   localparam logic [1:0] SAMT_SHAMT = 2'd0;
   localparam logic [1:0] SAMT_B     = 2'd1;

   localparam logic       SHSRC_A = 1'b0;
   localparam logic       SHSRC_B = 1'b1;

   localparam logic [2:0] SH_NOP  = 3'b000;
   localparam logic [2:0] SH_LOAD = 3'b001;
   localparam logic [2:0] SH_SLL  = 3'b010;
   localparam logic [2:0] SH_SRL  = 3'b011;
   localparam logic [2:0] SH_SRA  = 3'b100;

   typedef enum logic [STATE_W-1:0] {
      ST_RESET, ST_SP_INIT, ST_FETCH0, ST_FETCH_WAIT, ST_FETCH2, ST_DECODE,
      ST_EXEC, ST_EXEC_I, ST_WB_R, ST_WB_I, ST_SH_LOAD, ST_SH_OP, ST_JR,
      ST_ADDR, ST_MEM_RD, ST_MDR_LD, ST_WB_LW, ST_MEM_WR, ST_BRANCH,
      ST_JUMP, ST_JAL_WB, ST_EXC_OP, ST_EXC_OVF, ST_EXC_RD_OP,
      ST_EXC_RD_OVF, ST_EXC_MDR, ST_EXC_PC
   } state_e;

   typedef struct packed {
      logic       pc_write;
      logic       wr;
      logic       ab_load;
      logic       aluout_load;
      logic       epc_load;
      logic       mdr_load;
      logic       sel_ir;
      logic       regwrite;
      logic       sel_shift_src;
      logic       sel_alusrca;
      logic [1:0] sel_alusrcb;
      logic [2:0] alu_op;
      logic [2:0] sel_mux_iord;
      logic [2:0] sel_pc_source;
      logic [1:0] sel_regdst;
      logic [2:0] sel_memtoreg;
      logic [1:0] sel_shift_amt;
      logic [2:0] sel_shift_reg;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/funct_decoder.sv
// R-type funct field decoder: ALU operation, shift kind and instruction class flags.
module funct_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [OP_W-1:0] funct_i,
   output logic [2:0]      alu_op_c_o,
   output logic [2:0]      shift_op_c_o,
   output logic            is_shift_c_o,
   output logic            is_slt_c_o,
   output logic            is_jr_c_o,
   output logic            valid_c_o
);

   always_comb begin
      alu_op_c_o   = ALU_PASSA;
      shift_op_c_o = SH_NOP;
      is_shift_c_o = 1'b0;
      is_slt_c_o   = 1'b0;
      is_jr_c_o    = 1'b0;
      valid_c_o    = 1'b1;
      case (funct_i)
         FN_ADD: alu_op_c_o = ALU_ADD;
         FN_SUB: alu_op_c_o = ALU_SUB;
         FN_AND: alu_op_c_o = ALU_AND;
         FN_SLT: begin
            alu_op_c_o = ALU_CMP;
            is_slt_c_o = 1'b1;
         end
         FN_SLL: begin
            is_shift_c_o = 1'b1;
            shift_op_c_o = SH_SLL;
         end
         FN_SRL: begin
            is_shift_c_o = 1'b1;
            shift_op_c_o = SH_SRL;
         end
         FN_SRA: begin
            is_shift_c_o = 1'b1;
            shift_op_c_o = SH_SRA;
         end
         FN_JR:   is_jr_c_o = 1'b1;
         default: valid_c_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS main control FSM: sequences datapath enables/selects per cycle,
// dispatches on opcode/funct and handles invalid-opcode and overflow exceptions.
module control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1
)(
   input  logic            clk,
   input  logic            reset,
   input  logic [OP_W-1:0] opcode,
   input  logic [OP_W-1:0] funct,
   input  logic            alu_eq,
   input  logic            alu_ovf,
   output logic            PC_write,
   output logic            wr,
   output logic            AB_load,
   output logic            aluout_load,
   output logic            EPC_load,
   output logic            MDR_load,
   output logic            sel_ir,
   output logic            regwrite,
   output logic            sel_shift_src,
   output logic            sel_alusrca,
   output logic [1:0]      sel_alusrcb,
   output logic [2:0]      alu_op,
   output logic [2:0]      sel_mux_iord,
   output logic [2:0]      sel_pc_source,
   output logic [1:0]      sel_regdst,
   output logic [2:0]      sel_memtoreg,
   output logic [1:0]      sel_shift_amt,
   output logic [2:0]      sel_shift_reg
);

   localparam int unsigned WAIT_W = $clog2(MEM_WAIT + 2);
   // Data/fetch reads hold their state MEM_WAIT cycles; exception reads add an address cycle.
   localparam logic [WAIT_W-1:0] MEM_LAST = WAIT_W'(MEM_WAIT - 1);
   localparam logic [WAIT_W-1:0] EXC_LAST = WAIT_W'(MEM_WAIT);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   ctrl_t             ctrl_q, ctrl_d;

   logic [2:0] dec_alu_op, dec_shift_op;
   logic       dec_is_shift, dec_is_slt, dec_is_jr, dec_valid;
   logic       ovf_chk_c, br_take_c;

   funct_decoder u_funct_decoder (
      .funct_i      (funct),
      .alu_op_c_o   (dec_alu_op),
      .shift_op_c_o (dec_shift_op),
      .is_shift_c_o (dec_is_shift),
      .is_slt_c_o   (dec_is_slt),
      .is_jr_c_o    (dec_is_jr),
      .valid_c_o    (dec_valid)
   );

   assign ovf_chk_c = (dec_alu_op == ALU_ADD) || (dec_alu_op == ALU_SUB);
   assign br_take_c = (state_q == ST_BRANCH) &&
                      (((opcode == OP_BEQ) && alu_eq) || ((opcode == OP_BNE) && !alu_eq));

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:      state_d = ST_SP_INIT;
         ST_SP_INIT:    state_d = ST_FETCH0;
         ST_FETCH0:     state_d = ST_FETCH_WAIT;
         ST_FETCH_WAIT: state_d = (wait_q == MEM_LAST) ? ST_FETCH2 : ST_FETCH_WAIT;
         ST_FETCH2:     state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE: begin
                  if (!dec_valid)        state_d = ST_EXC_OP;
                  else if (dec_is_jr)    state_d = ST_JR;
                  else if (dec_is_shift) state_d = ST_SH_LOAD;
                  else                   state_d = ST_EXEC;
               end
               OP_ADDI:      state_d = ST_EXEC_I;
               OP_LW, OP_SW: state_d = ST_ADDR;
               OP_BEQ, OP_BNE: state_d = ST_BRANCH;
               OP_J:         state_d = ST_JUMP;
               OP_JAL:       state_d = ST_JAL_WB;
               default:      state_d = ST_EXC_OP;
            endcase
         end
         ST_EXEC:       state_d = (alu_ovf && ovf_chk_c) ? ST_EXC_OVF : ST_WB_R;
         ST_EXEC_I:     state_d = alu_ovf ? ST_EXC_OVF : ST_WB_I;
         ST_SH_LOAD:    state_d = ST_SH_OP;
         ST_SH_OP:      state_d = ST_WB_R;
         ST_ADDR:       state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD:     state_d = (wait_q == MEM_LAST) ? ST_MDR_LD : ST_MEM_RD;
         ST_MDR_LD:     state_d = ST_WB_LW;
         ST_JAL_WB:     state_d = ST_JUMP;
         ST_EXC_OP:     state_d = ST_EXC_RD_OP;
         ST_EXC_OVF:    state_d = ST_EXC_RD_OVF;
         ST_EXC_RD_OP, ST_EXC_RD_OVF:
                        state_d = (wait_q == EXC_LAST) ? ST_EXC_MDR : state_q;
         ST_EXC_MDR:    state_d = ST_EXC_PC;
         ST_WB_R, ST_WB_I, ST_JR, ST_WB_LW, ST_MEM_WR, ST_BRANCH, ST_JUMP, ST_EXC_PC:
                        state_d = ST_FETCH0;
         default:       state_d = ST_RESET;
      endcase
   end

   // Only wait states self-loop, so the counter restarts on every state change.
   assign wait_d = (state_d == state_q) ? wait_q + WAIT_W'(1) : '0;

   // Control word for the state about to be entered, so outputs leave a register.
   always_comb begin
      ctrl_d = CTRL_IDLE;
      case (state_d)
         ST_SP_INIT: begin
            ctrl_d.regwrite     = 1'b1;
            ctrl_d.sel_regdst   = RD_SP;
            ctrl_d.sel_memtoreg = M2R_SP;
         end
         ST_FETCH0, ST_FETCH_WAIT: ctrl_d.sel_mux_iord = IORD_PC;
         ST_FETCH2: begin
            ctrl_d.sel_ir        = 1'b1;
            ctrl_d.sel_alusrca   = ALUA_PC;
            ctrl_d.sel_alusrcb   = ALUB_4;
            ctrl_d.alu_op        = ALU_ADD;
            ctrl_d.sel_pc_source = PCS_ALU;
            ctrl_d.pc_write      = 1'b1;
         end
         ST_DECODE: begin
            ctrl_d.ab_load     = 1'b1;
            ctrl_d.aluout_load = 1'b1;
            ctrl_d.sel_alusrca = ALUA_PC;
            ctrl_d.sel_alusrcb = ALUB_SEXT_SH;
            ctrl_d.alu_op      = ALU_ADD;
         end
         ST_EXEC: begin
            ctrl_d.sel_alusrca = ALUA_A;
            ctrl_d.sel_alusrcb = ALUB_B;
            ctrl_d.alu_op      = dec_alu_op;
            ctrl_d.aluout_load = 1'b1;
         end
         ST_EXEC_I, ST_ADDR: begin
            ctrl_d.sel_alusrca = ALUA_A;
            ctrl_d.sel_alusrcb = ALUB_SEXT;
            ctrl_d.alu_op      = ALU_ADD;
            ctrl_d.aluout_load = 1'b1;
         end
         ST_WB_R: begin
            ctrl_d.regwrite     = 1'b1;
            ctrl_d.sel_regdst   = RD_RD;
            ctrl_d.sel_memtoreg = dec_is_shift ? M2R_SHIFT :
                                  dec_is_slt   ? M2R_LT    : M2R_ALUOUT;
         end
         ST_WB_I: begin
            ctrl_d.regwrite     = 1'b1;
            ctrl_d.sel_regdst   = RD_RT;
            ctrl_d.sel_memtoreg = M2R_ALUOUT;
         end
         ST_SH_LOAD: begin
            ctrl_d.sel_shift_reg = SH_LOAD;
            ctrl_d.sel_shift_src = SHSRC_B;
            ctrl_d.sel_shift_amt = SAMT_SHAMT;
         end
         ST_SH_OP: begin
            ctrl_d.sel_shift_reg = dec_shift_op;
            ctrl_d.sel_shift_amt = SAMT_SHAMT;
         end
         ST_JR: begin
            ctrl_d.pc_write      = 1'b1;
            ctrl_d.sel_pc_source = PCS_A;
         end
         ST_MEM_RD: ctrl_d.sel_mux_iord = IORD_ALUOUT;
         ST_MDR_LD, ST_EXC_MDR: ctrl_d.mdr_load = 1'b1;
         ST_WB_LW: begin
            ctrl_d.regwrite     = 1'b1;
            ctrl_d.sel_regdst   = RD_RT;
            ctrl_d.sel_memtoreg = M2R_MDR;
         end
         ST_MEM_WR: begin
            ctrl_d.sel_mux_iord = IORD_ALUOUT;
            ctrl_d.wr           = 1'b1;
         end
         ST_BRANCH: begin
            ctrl_d.sel_alusrca   = ALUA_A;
            ctrl_d.sel_alusrcb   = ALUB_B;
            ctrl_d.alu_op        = ALU_SUB;
            ctrl_d.sel_pc_source = PCS_ALUOUT;
         end
         ST_JUMP: begin
            ctrl_d.pc_write      = 1'b1;
            ctrl_d.sel_pc_source = PCS_JUMP;
         end
         ST_JAL_WB: begin
            ctrl_d.regwrite     = 1'b1;
            ctrl_d.sel_regdst   = RD_RA;
            ctrl_d.sel_memtoreg = M2R_PC;
         end
         ST_EXC_OP, ST_EXC_OVF: begin
            ctrl_d.epc_load    = 1'b1;
            ctrl_d.sel_alusrca = ALUA_PC;
            ctrl_d.sel_alusrcb = ALUB_4;
            ctrl_d.alu_op      = ALU_SUB;
         end
         ST_EXC_RD_OP:  ctrl_d.sel_mux_iord = IORD_OPC;
         ST_EXC_RD_OVF: ctrl_d.sel_mux_iord = IORD_OVF;
         ST_EXC_PC: begin
            ctrl_d.pc_write      = 1'b1;
            ctrl_d.sel_pc_source = PCS_MDR;
         end
         default: ctrl_d = CTRL_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RESET;
         wait_q  <= '0;
         ctrl_q  <= CTRL_IDLE;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Branch decision needs the flag from the compare done in the same cycle.
   assign PC_write      = ctrl_q.pc_write | br_take_c;
   assign wr            = ctrl_q.wr;
   assign AB_load       = ctrl_q.ab_load;
   assign aluout_load   = ctrl_q.aluout_load;
   assign EPC_load      = ctrl_q.epc_load;
   assign MDR_load      = ctrl_q.mdr_load;
   assign sel_ir        = ctrl_q.sel_ir;
   assign regwrite      = ctrl_q.regwrite;
   assign sel_shift_src = ctrl_q.sel_shift_src;
   assign sel_alusrca   = ctrl_q.sel_alusrca;
   assign sel_alusrcb   = ctrl_q.sel_alusrcb;
   assign alu_op        = ctrl_q.alu_op;
   assign sel_mux_iord  = ctrl_q.sel_mux_iord;
   assign sel_pc_source = ctrl_q.sel_pc_source;
   assign sel_regdst    = ctrl_q.sel_regdst;
   assign sel_memtoreg  = ctrl_q.sel_memtoreg;
   assign sel_shift_amt = ctrl_q.sel_shift_amt;
   assign sel_shift_reg = ctrl_q.sel_shift_reg;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level reference model queues the
// expected per-cycle control words, a negedge monitor pops and compares them.
module tb_control_unit;

   localparam int MEM_WAIT = 1;

   typedef struct packed {
      logic       pc_write, wr, ab_load, aluout_load, epc_load, mdr_load, sel_ir, regwrite;
      logic       shift_src, alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alu_op;
      logic [2:0] iord;
      logic [2:0] pcsrc;
      logic [1:0] regdst;
      logic [2:0] m2r;
      logic [1:0] samt;
      logic [2:0] sreg;
   } cw_t;

   logic       clk, reset;
   logic [5:0] opcode, funct;
   logic       alu_eq, alu_ovf;
   logic       PC_write, wr, AB_load, aluout_load, EPC_load, MDR_load, sel_ir, regwrite;
   logic       sel_shift_src, sel_alusrca;
   logic [1:0] sel_alusrcb, sel_regdst, sel_shift_amt;
   logic [2:0] alu_op, sel_mux_iord, sel_pc_source, sel_memtoreg, sel_shift_reg;

   control_unit #(.MEM_WAIT(MEM_WAIT)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .alu_eq(alu_eq), .alu_ovf(alu_ovf),
      .PC_write(PC_write), .wr(wr), .AB_load(AB_load), .aluout_load(aluout_load),
      .EPC_load(EPC_load), .MDR_load(MDR_load), .sel_ir(sel_ir), .regwrite(regwrite),
      .sel_shift_src(sel_shift_src), .sel_alusrca(sel_alusrca), .sel_alusrcb(sel_alusrcb),
      .alu_op(alu_op), .sel_mux_iord(sel_mux_iord), .sel_pc_source(sel_pc_source),
      .sel_regdst(sel_regdst), .sel_memtoreg(sel_memtoreg),
      .sel_shift_amt(sel_shift_amt), .sel_shift_reg(sel_shift_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cw_t   exp_q[$];
   string tag_q[$];
   string cur_tag;
   int    cyc;
   int    n_checks = 0;
   int    n_fail   = 0;

   function automatic void push(input cw_t w);
      exp_q.push_back(w);
      tag_q.push_back($sformatf("%s c%0d", cur_tag, cyc));
      cyc++;
   endfunction

   function automatic void push_exc(input bit ovf_kind);
      cw_t w;
      w = '0; w.epc_load = 1; w.alusrcb = 2'd1; w.alu_op = 3'b010; push(w);
      for (int i = 0; i <= MEM_WAIT; i++) begin
         w = '0; w.iord = ovf_kind ? 3'd3 : 3'd2; push(w);
      end
      w = '0; w.mdr_load = 1; push(w);
      w = '0; w.pc_write = 1; w.pcsrc = 3'd3; push(w);
   endfunction

   // Whole-instruction expectation built from the instruction's architectural meaning.
   function automatic int model(input logic [5:0] op, input logic [5:0] fn,
                                input logic eq, input logic ovf);
      cw_t w;
      int  n0;
      n0  = exp_q.size();
      cyc = 1;
      cur_tag = $sformatf("op%02h/fn%02h eq%0d ovf%0d", op, fn, eq, ovf);
      w = '0; push(w);
      for (int i = 0; i < MEM_WAIT; i++) push('0);
      w = '0; w.sel_ir = 1; w.alusrcb = 2'd1; w.alu_op = 3'b001; w.pc_write = 1; push(w);
      w = '0; w.ab_load = 1; w.aluout_load = 1; w.alusrcb = 2'd3; w.alu_op = 3'b001; push(w);
      case (op)
         6'h00: begin
            case (fn)
               6'h20, 6'h22, 6'h24, 6'h2A: begin
                  w = '0; w.alusrca = 1; w.aluout_load = 1;
                  w.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 :
                             (fn == 6'h24) ? 3'b011 : 3'b111;
                  push(w);
                  if (ovf && (fn == 6'h20 || fn == 6'h22)) push_exc(1'b1);
                  else begin
                     w = '0; w.regwrite = 1; w.regdst = 2'd1;
                     w.m2r = (fn == 6'h2A) ? 3'd3 : 3'd0; push(w);
                  end
               end
               6'h00, 6'h02, 6'h03: begin
                  w = '0; w.sreg = 3'b001; w.shift_src = 1; push(w);
                  w = '0; w.sreg = (fn == 6'h00) ? 3'b010 : (fn == 6'h02) ? 3'b011 : 3'b100;
                  push(w);
                  w = '0; w.regwrite = 1; w.regdst = 2'd1; w.m2r = 3'd2; push(w);
               end
               6'h08: begin
                  w = '0; w.pc_write = 1; w.pcsrc = 3'd4; push(w);
               end
               default: push_exc(1'b0);
            endcase
         end
         6'h08: begin
            w = '0; w.alusrca = 1; w.alusrcb = 2'd2; w.alu_op = 3'b001; w.aluout_load = 1;
            push(w);
            if (ovf) push_exc(1'b1);
            else begin
               w = '0; w.regwrite = 1; push(w);
            end
         end
         6'h23, 6'h2B: begin
            w = '0; w.alusrca = 1; w.alusrcb = 2'd2; w.alu_op = 3'b001; w.aluout_load = 1;
            push(w);
            if (op == 6'h2B) begin
               w = '0; w.iord = 3'd1; w.wr = 1; push(w);
            end else begin
               for (int i = 0; i < MEM_WAIT; i++) begin
                  w = '0; w.iord = 3'd1; push(w);
               end
               w = '0; w.mdr_load = 1; push(w);
               w = '0; w.regwrite = 1; w.m2r = 3'd1; push(w);
            end
         end
         6'h04, 6'h05: begin
            w = '0; w.alusrca = 1; w.alu_op = 3'b010; w.pcsrc = 3'd1;
            w.pc_write = (op == 6'h04) ? eq : !eq; push(w);
         end
         6'h02, 6'h03: begin
            if (op == 6'h03) begin
               w = '0; w.regwrite = 1; w.regdst = 2'd2; w.m2r = 3'd5; push(w);
            end
            w = '0; w.pc_write = 1; w.pcsrc = 3'd2; push(w);
         end
         default: push_exc(1'b0);
      endcase
      return exp_q.size() - n0;
   endfunction

   // Scoreboard monitor: samples mid-cycle, away from the active edge.
   always @(negedge clk) begin
      cw_t   act, exp_w;
      string tag;
      if (exp_q.size() > 0) begin
         exp_w = exp_q.pop_front();
         tag   = tag_q.pop_front();
         act   = {PC_write, wr, AB_load, aluout_load, EPC_load, MDR_load, sel_ir, regwrite,
                  sel_shift_src, sel_alusrca, sel_alusrcb, alu_op, sel_mux_iord,
                  sel_pc_source, sel_regdst, sel_memtoreg, sel_shift_amt, sel_shift_reg};
         n_checks++;
         if (act !== exp_w) begin
            n_fail++;
            $display("FAIL ctrl_word [%s] at %0t: got %08h expected %08h", tag, $time,
                     act, exp_w);
         end
      end
   end

   // All driver actions happen 1 time unit after a rising edge.
   task automatic run(input logic [5:0] op, input logic [5:0] fn,
                      input logic eq, input logic ovf);
      int n;
      opcode = op; funct = fn; alu_eq = eq; alu_ovf = ovf;
      n = model(op, fn, eq, ovf);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      cw_t w;
      cur_tag = "reset"; cyc = 0;
      reset = 1'b0;
      push('0);
      @(posedge clk); #1;
      push('0);
      reset = 1'b1;
      @(posedge clk); #1;
      cur_tag = "sp_init";
      w = '0; w.regwrite = 1; w.regdst = 2'd3; w.m2r = 3'd4; push(w);
      @(posedge clk); #1;
   endtask

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 11))
         0, 1, 2: return 6'h00;
         3:       return 6'h02;
         4:       return 6'h03;
         5:       return 6'h04;
         6:       return 6'h05;
         7:       return 6'h08;
         8:       return 6'h23;
         9:       return 6'h2B;
         10:      return 6'h3F;
         default: return 6'($urandom);
      endcase
   endfunction

   function automatic logic [5:0] pick_fn();
      case ($urandom_range(0, 9))
         0:       return 6'h20;
         1:       return 6'h22;
         2:       return 6'h24;
         3:       return 6'h2A;
         4:       return 6'h00;
         5:       return 6'h02;
         6:       return 6'h03;
         7:       return 6'h08;
         default: return 6'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b0; opcode = '0; funct = '0; alu_eq = 1'b0; alu_ovf = 1'b0;
      @(posedge clk); #1;
      do_reset();

      run(6'h00, 6'h20, 1'b0, 1'b0);
      run(6'h00, 6'h20, 1'b0, 1'b1);
      run(6'h04, 6'h00, 1'b1, 1'b0);
      run(6'h04, 6'h00, 1'b0, 1'b0);
      run(6'h05, 6'h00, 1'b1, 1'b0);
      run(6'h05, 6'h00, 1'b0, 1'b0);
      run(6'h23, 6'h00, 1'b0, 1'b1);
      run(6'h2B, 6'h00, 1'b0, 1'b0);
      run(6'h3F, 6'h20, 1'b0, 1'b0);
      run(6'h00, 6'h22, 1'b0, 1'b1);
      run(6'h00, 6'h24, 1'b0, 1'b1);
      run(6'h00, 6'h2A, 1'b0, 1'b1);
      run(6'h00, 6'h00, 1'b0, 1'b0);
      run(6'h00, 6'h02, 1'b0, 1'b0);
      run(6'h00, 6'h03, 1'b0, 1'b0);
      run(6'h00, 6'h08, 1'b0, 1'b0);
      run(6'h00, 6'h3F, 1'b0, 1'b0);
      run(6'h08, 6'h00, 1'b0, 1'b0);
      run(6'h08, 6'h00, 1'b0, 1'b1);
      run(6'h02, 6'h00, 1'b0, 1'b0);
      run(6'h03, 6'h00, 1'b0, 1'b0);

      // Abort an add during FETCH2 with an asynchronous reset.
      opcode = 6'h00; funct = 6'h20; alu_eq = 1'b0; alu_ovf = 1'b0;
      cur_tag = "pre_abort"; cyc = 1;
      push('0);
      for (int i = 0; i < MEM_WAIT; i++) push('0);
      repeat (1 + MEM_WAIT) begin @(posedge clk); #1; end
      do_reset();

      for (int k = 0; k < 160; k++)
         run(pick_op(), pick_fn(), 1'($urandom), 1'($urandom));

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
